spi_sched: RTL and testbench

Round-robin scheduler that shares one SPI byte engine between NREQ requesters. It grants one requester at a time and owns chip-select (CS) for the whole burst. It feeds the requester's bytes to the engine one per transfer, returns each received byte tagged with the requester id, and enforces CS setup and inter-burst gap timing. A watchdog aborts a burst if the engine stalls.

---
 rtl/spi_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sched.sv
// Round-robin arbiter sharing one SPI byte engine; the granted requester owns CS for its whole burst.
// All outputs registered (gnt 1 cycle after req); LOAD holds off while eng_busy; watchdog aborts a stalled word.
module spi_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LW    = 4,
  parameter int CSS   = 2,
  parameter int GAP   = 4,
  parameter int WDOG  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LW-1:0]       len,
  input  logic [NREQ*WIDTH-1:0]    din,
  output logic [NREQ-1:0]          pop,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     err,
  output logic [WIDTH-1:0]         rx_dout,
  output logic                     rx_vld,
  output logic [$clog2(NREQ)-1:0]  rx_id,
  output logic                     cs_n,
  output logic                     eng_vld,
  output logic [WIDTH-1:0]         eng_din,
  input  logic                     eng_busy,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_dout
);

  localparam int IW   = $clog2(NREQ);
  localparam int TMAX = (CSS > GAP) ? CSS : GAP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int WW   = $clog2(WDOG + 1);

  localparam logic [TW-1:0] CSS_LAST  = TW'((CSS > 0) ? CSS - 1 : 0);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_XFER,
    S_GAP
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    win, win_n;
  logic [IW-1:0]    rr, rr_n;
  logic [LW-1:0]    cnt, cnt_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic [WW-1:0]    wdg, wdg_n;

  logic [NREQ-1:0]  pop_n, gnt_n, done_n;
  logic             err_n, rx_vld_n, cs_n_n, eng_vld_n;
  logic [WIDTH-1:0] rx_dout_n, eng_din_n;
  logic [IW-1:0]    rx_id_n;

  logic             arb_hit;
  logic [IW-1:0]    arb_idx;
  logic             end_burst;

  logic [LW-1:0]    len_a [NREQ];
  logic [WIDTH-1:0] din_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign len_a[g] = len[g*LW +: LW];
    assign din_a[g] = din[g*WIDTH +: WIDTH];
  end

  // Modulo-NREQ add, valid for non-power-of-2 NREQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

  // First set request at or after the round-robin pointer.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_hit && req[wrap_add(rr, i)]) begin
        arb_hit = 1'b1;
        arb_idx = wrap_add(rr, i);
      end
    end
  end

  always_comb begin
    state_n   = state;
    win_n     = win;
    rr_n      = rr;
    cnt_n     = cnt;
    tmr_n     = tmr;
    wdg_n     = wdg;
    gnt_n     = gnt;
    cs_n_n    = cs_n;
    eng_din_n = eng_din;
    rx_dout_n = rx_dout;
    rx_id_n   = rx_id;
    pop_n     = '0;
    done_n    = '0;
    err_n     = 1'b0;
    rx_vld_n  = 1'b0;
    eng_vld_n = 1'b0;
    end_burst = 1'b0;

    case (state)
      S_IDLE: begin
        cs_n_n = 1'b1;
        if (arb_hit) begin
          win_n   = arb_idx;
          gnt_n   = onehot(arb_idx);
          cnt_n   = len_a[arb_idx];
          cs_n_n  = 1'b0;
          tmr_n   = '0;
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (CSS == 0 || tmr == CSS_LAST) begin
          state_n = S_LOAD;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      S_LOAD: begin
        if (!eng_busy) begin
          eng_vld_n = 1'b1;
          eng_din_n = din_a[win];
          pop_n     = onehot(win);
          wdg_n     = '0;
          state_n   = S_XFER;
        end
      end
      S_XFER: begin
        // A completing word beats a watchdog expiry in the same cycle.
        if (eng_done) begin
          rx_vld_n  = 1'b1;
          rx_dout_n = eng_dout;
          rx_id_n   = win;
          if (cnt == '0) begin
            end_burst = 1'b1;
          end else begin
            cnt_n   = cnt - 1'b1;
            state_n = S_LOAD;
          end
        end else if (wdg == WDOG_LAST) begin
          err_n     = 1'b1;
          end_burst = 1'b1;
        end else begin
          wdg_n = wdg + 1'b1;
        end
      end
      S_GAP: begin
        cs_n_n = 1'b1;
        if (tmr == GAP_LAST) begin
          state_n = S_IDLE;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cs_n_n  = 1'b1;
        gnt_n   = '0;
      end
    endcase

    if (end_burst) begin
      done_n  = onehot(win);
      gnt_n   = '0;
      rr_n    = wrap_add(win, 1);
      cs_n_n  = 1'b1;
      tmr_n   = '0;
      state_n = S_GAP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      win     <= '0;
      rr      <= '0;
      cnt     <= '0;
      tmr     <= '0;
      wdg     <= '0;
      gnt     <= '0;
      pop     <= '0;
      done    <= '0;
      err     <= 1'b0;
      rx_vld  <= 1'b0;
      rx_dout <= '0;
      rx_id   <= '0;
      cs_n    <= 1'b1;
      eng_vld <= 1'b0;
      eng_din <= '0;
    end else begin
      state   <= state_n;
      win     <= win_n;
      rr      <= rr_n;
      cnt     <= cnt_n;
      tmr     <= tmr_n;
      wdg     <= wdg_n;
      gnt     <= gnt_n;
      pop     <= pop_n;
      done    <= done_n;
      err     <= err_n;
      rx_vld  <= rx_vld_n;
      rx_dout <= rx_dout_n;
      rx_id   <= rx_id_n;
      cs_n    <= cs_n_n;
      eng_vld <= eng_vld_n;
      eng_din <= eng_din_n;
    end
  end

endmodule

// File: tb/tb_spi_sched.sv
// Scoreboard bench for spi_sched: stimulus pushes expected grants/words/rx/done, a monitor pops and compares.
module tb_spi_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LW    = 4;
  localparam int CSS   = 2;
  localparam int GAP   = 4;
  localparam int WDOG  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*LW-1:0]      len;
  logic [NREQ*WIDTH-1:0]   din;
  logic [NREQ-1:0]         pop, gnt, done;
  logic                    err, rx_vld, cs_n, eng_vld;
  logic [WIDTH-1:0]        rx_dout, eng_din;
  logic [1:0]              rx_id;
  logic                    eng_busy, eng_done;
  logic [WIDTH-1:0]        eng_dout;
  logic                    eng_hang;

  int checks = 0;
  int passed = 0;

  logic [NREQ-1:0] exp_gnt_q [$];
  logic [7:0]      exp_eng_q [$];
  logic [15:0]     exp_rx_q  [$];
  logic [4:0]      exp_done_q[$];

  spi_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LW(LW), .CSS(CSS), .GAP(GAP), .WDOG(WDOG)) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .din(din),
    .pop(pop), .gnt(gnt), .done(done), .err(err),
    .rx_dout(rx_dout), .rx_vld(rx_vld), .rx_id(rx_id), .cs_n(cs_n),
    .eng_vld(eng_vld), .eng_din(eng_din),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_dout(eng_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] got);
    checks++;
    $display("FAIL %s: got unexpected %0h expected nothing", name, got);
  endtask

  // Engine model: echoes ~din 10 cycles after launch; hang mode never completes.
  int ecnt = 0;
  logic [7:0] ebuf;
  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    eng_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) begin
          eng_done = 1'b1;
          eng_dout = ~ebuf;
          eng_busy = 1'b0;
        end
      end else if (eng_vld && !eng_hang) begin
        ebuf     = eng_din;
        ecnt     = 10;
        eng_busy = 1'b1;
      end
    end
  end

  // Requester 2 presents a fresh word after each pop.
  initial begin
    forever begin
      @(negedge clk);
      if (pop[2]) din[23:16] = din[23:16] + 8'd1;
    end
  end

  logic [NREQ-1:0] prev_gnt;
  initial begin
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (gnt != 0 && prev_gnt == 0) begin
          if (exp_gnt_q.size() == 0) unexpected("gnt", gnt);
          else check("gnt", gnt, exp_gnt_q.pop_front());
        end
        if (eng_vld) begin
          if (exp_eng_q.size() == 0) unexpected("eng_din", eng_din);
          else check("eng_din", eng_din, exp_eng_q.pop_front());
          check("pop_vs_gnt", pop, gnt);
        end else if (pop != 0) begin
          unexpected("pop_without_eng_vld", pop);
        end
        if (rx_vld) begin
          if (exp_rx_q.size() == 0) unexpected("rx", {rx_dout, 6'd0, rx_id});
          else check("rx", {rx_dout, 6'd0, rx_id}, exp_rx_q.pop_front());
        end
        if (done != 0 || err) begin
          if (exp_done_q.size() == 0) unexpected("done_err", {err, done});
          else check("done_err", {err, done}, exp_done_q.pop_front());
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 0 && n < 200);
    if (gnt == 0) unexpected("timeout_gnt", 32'd0);
  endtask

  task automatic wait_eng(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!eng_vld && n < 200);
    if (!eng_vld) unexpected("timeout_eng_vld", 32'd0);
  endtask

  task automatic wait_done(output int n, output int hi, output int pops);
    n = 0; hi = 0; pops = 0;
    forever begin
      @(negedge clk);
      n++;
      if (done != 0) break;
      if (cs_n) hi++;
      if (pop != 0) pops++;
      if (n >= 400) begin
        unexpected("timeout_done", 32'd0);
        break;
      end
    end
  endtask

  int n, hi, pops;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; len = '0; din = '0; eng_hang = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cs_n", cs_n, 1);
    check("rst_gnt", gnt, 0);
    check("rst_pop", pop, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rx_vld", rx_vld, 0);
    check("rst_eng_vld", eng_vld, 0);
    check("rst_rx_dout", rx_dout, 0);
    check("rst_rx_id", rx_id, 0);
    check("rst_eng_din", eng_din, 0);

    // Single word to requester 0
    din[7:0] = 8'hA5;
    exp_gnt_q.push_back(4'b0001);
    exp_eng_q.push_back(8'hA5);
    exp_rx_q.push_back({8'h5A, 8'd0});
    exp_done_q.push_back({1'b0, 4'b0001});
    req = 4'b0001;
    wait_gnt(n);
    check("t1_gnt_latency", n, 1);
    check("t1_cs_low_at_gnt", cs_n, 0);
    req = '0;
    wait_eng(n);
    check("t1_setup_to_launch", n, CSS + 1);
    check("t1_cs_low_at_launch", cs_n, 0);
    wait_done(n, hi, pops);
    check("t1_launch_to_done", n, 11);
    check("t1_cs_low_during_burst", hi, 0);
    hi = 0;
    for (int i = 0; i < GAP; i++) begin
      if (cs_n) hi++;
      if (i < GAP - 1) @(negedge clk);
    end
    check("t1_cs_high_gap", hi, GAP);

    // Round robin between 1 and 3
    din[15:8] = 8'h31;
    din[31:24] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      exp_gnt_q.push_back((k % 2 == 0) ? 4'b0010 : 4'b1000);
      exp_eng_q.push_back((k % 2 == 0) ? 8'h31 : 8'h33);
      exp_rx_q.push_back((k % 2 == 0) ? {8'hCE, 8'd1} : {8'hCC, 8'd3});
      exp_done_q.push_back({1'b0, (k % 2 == 0) ? 4'b0010 : 4'b1000});
    end
    req = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      if (k > 0) check("t2_done_to_gnt", n, GAP + 1);
      wait_done(n, hi, pops);
      if (k == 3) req = '0;
    end

    // Four-word burst from requester 2
    len[11:8] = 4'd3;
    din[23:16] = 8'h10;
    exp_gnt_q.push_back(4'b0100);
    for (int w = 0; w < 4; w++) begin
      exp_eng_q.push_back(8'h10 + 8'(w));
      exp_rx_q.push_back({8'hEF - 8'(w), 8'd2});
    end
    exp_done_q.push_back({1'b0, 4'b0100});
    req = 4'b0100;
    wait_gnt(n);
    req = '0;
    wait_done(n, hi, pops);
    check("t3_cs_never_rises", hi, 0);
    check("t3_pop_count", pops, 4);

    // Watchdog abort, then requester 1 is served
    eng_hang = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    exp_eng_q.push_back(8'hA5);
    exp_done_q.push_back({1'b1, 4'b0001});
    req = 4'b0001;
    wait_gnt(n);
    req = '0;
    wait_eng(n);
    wait_done(n, hi, pops);
    check("t4_wdog_cycles", n, WDOG);
    check("t4_err_pulse", err, 1);
    check("t4_cs_high_after_abort", cs_n, 1);
    eng_hang = 1'b0;
    exp_gnt_q.push_back(4'b0010);
    exp_eng_q.push_back(8'h31);
    exp_rx_q.push_back({8'hCE, 8'd1});
    exp_done_q.push_back({1'b0, 4'b0010});
    req = 4'b0010;
    wait_gnt(n);
    req = '0;
    wait_done(n, hi, pops);

    // Reset during the second word of a four-word burst
    len[11:8] = 4'd3;
    din[23:16] = 8'h20;
    exp_gnt_q.push_back(4'b0100);
    exp_eng_q.push_back(8'h20);
    exp_eng_q.push_back(8'h21);
    exp_rx_q.push_back({8'hDF, 8'd2});
    req = 4'b0100;
    wait_gnt(n);
    req = '0;
    wait_eng(n);
    wait_eng(n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_cs_high_after_rst", cs_n, 1);
    check("t5_gnt_clear_after_rst", gnt, 0);
    // Pointer back at 0: req 1001 must go to 0, the stale eng_done must not surface
    len[3:0] = 4'd0;
    din[7:0] = 8'h5C;
    exp_gnt_q.push_back(4'b0001);
    exp_eng_q.push_back(8'h5C);
    exp_rx_q.push_back({8'hA3, 8'd0});
    exp_done_q.push_back({1'b0, 4'b0001});
    req = 4'b1001;
    wait_gnt(n);
    req = '0;
    wait_done(n, hi, pops);

    // req dropped after grant: all three words still move
    len[3:0] = 4'd2;
    din[7:0] = 8'h40;
    exp_gnt_q.push_back(4'b0001);
    for (int w = 0; w < 3; w++) begin
      exp_eng_q.push_back(8'h40);
      exp_rx_q.push_back({8'hBF, 8'd0});
    end
    exp_done_q.push_back({1'b0, 4'b0001});
    repeat (GAP + 1) @(negedge clk);
    req = 4'b0001;
    wait_gnt(n);
    req = '0;
    wait_done(n, hi, pops);
    check("t6_pop_count", pops, 3);
    repeat (30) @(negedge clk);

    check("gnt_q_drained", exp_gnt_q.size(), 0);
    check("eng_q_drained", exp_eng_q.size(), 0);
    check("rx_q_drained", exp_rx_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
